im_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the instruction memory (IM). It owns the fetch PC, drives the IM byte address, and captures the combinational read word into a small prefetch queue. The queue feeds decode over a valid/ready handshake. Redirects from execute (branch/jump) flush the queue and restart fetching; misaligned redirect targets raise a sticky fault.

---
 rtl/im_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_im_fetch_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns fetch PC, captures IM read words into a prefetch queue for decode.
// Latency: word fetched at edge N is the queue head after edge N; no comb im_rd-to-inst path.
// Backpressure: inst_ready=0 holds the head; queue fills to DEPTH, then fetch_pc stalls.
module im_fetch_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    output logic [ADDR_W-1:0]           im_addr,
    input  logic [DATA_W-1:0]           im_rd,
    output logic                        inst_valid,
    input  logic                        inst_ready,
    output logic [DATA_W-1:0]           inst,
    output logic [ADDR_W-1:0]           inst_pc,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        fault,
    output logic [ADDR_W-1:0]           fault_pc,
    output logic [$clog2(DEPTH):0]      q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q;
    logic [ADDR_W-1:0]   pc_mem  [DEPTH];
    logic [DATA_W-1:0]   dat_mem [DEPTH];
    logic [PW-1:0]       head_q, tail_q;
    logic [CW-1:0]       count_q;
    logic                fault_q;
    logic [ADDR_W-1:0]   fault_pc_q;

    logic flush, misalign, push, pop;

    // Redirects are ignored once faulted; a misaligned one flushes but keeps fetch_pc.
    assign flush    = redirect_valid & (state_q != FAULT);
    assign misalign = flush & (redirect_pc[1:0] != 2'b00);
    assign pop      = inst_valid & inst_ready;
    assign push     = (state_q == RUN) & ~redirect_valid &
                      ((count_q < CW'(DEPTH)) | pop);

    assign im_addr    = fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? dat_mem[head_q] : '0;
    assign inst_pc    = inst_valid ? pc_mem[head_q]  : '0;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;
    assign q_count    = count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (misalign)
                    state_d = FAULT;
                else if (!redirect_valid && en)
                    state_d = RUN;
            end
            RUN: begin
                if (misalign)
                    state_d = FAULT;
                else if (!redirect_valid && !en)
                    state_d = IDLE;
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= ADDR_W'(RESET_PC);
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                if (misalign) begin
                    fault_q    <= 1'b1;
                    fault_pc_q <= redirect_pc;
                end else begin
                    fetch_pc_q <= redirect_pc;
                end
            end else begin
                if (push) begin
                    tail_q     <= tail_q + PW'(1);
                    fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
                end
                if (pop)
                    head_q <= head_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]  <= fetch_pc_q;
            dat_mem[tail_q] <= im_rd;
        end
    end
endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: vector table plus hand sequences for redirect, wrap and enable corners.
module tb_im_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst, en, inst_ready, redirect_valid;
    logic [15:0] redirect_pc, im_addr, inst_pc, fault_pc;
    logic [31:0] im_rd, inst;
    logic        inst_valid, fault;
    logic [2:0]  q_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // IM model: word i holds value i
    assign im_rd = {18'h0, im_addr[15:2]};

    im_fetch_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .en(en), .im_addr(im_addr), .im_rd(im_rd),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fault(fault), .fault_pc(fault_pc), .q_count(q_count)
    );

    typedef struct {
        logic        rst, en, rdy, rv;
        logic [15:0] rpc;
        logic [15:0] e_addr;
        logic        e_vld;
        logic [15:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_qc;
        logic        e_fault;
        logic [15:0] e_fpc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, e, rd, rv, input logic [15:0] rpc,
                       input logic [15:0] a, input logic v, input logic [15:0] pc,
                       input logic [31:0] i, input logic [2:0] qc, input logic f,
                       input logic [15:0] fpc);
        vec_t t;
        t.rst = r; t.en = e; t.rdy = rd; t.rv = rv; t.rpc = rpc;
        t.e_addr = a; t.e_vld = v; t.e_pc = pc; t.e_inst = i;
        t.e_qc = qc; t.e_fault = f; t.e_fpc = fpc;
        vq.push_back(t);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] frozen;
        logic        seen;

        rst = 1'b1; en = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        //   rst en rdy rv rpc       addr     vld pc       inst   qc f fpc
        add(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 32'h0,  0, 0, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 32'h0,  0, 0, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h0004, 1, 16'h0000, 32'h0,  1, 0, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h0008, 1, 16'h0004, 32'h1,  1, 0, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h000C, 1, 16'h0008, 32'h2,  1, 0, 16'h0000);
        add(1, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 32'h0,  0, 0, 16'h0000);
        add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 32'h0,  0, 0, 16'h0000);
        add(0, 1, 0, 0, 16'h0000, 16'h0004, 1, 16'h0000, 32'h0,  1, 0, 16'h0000);
        add(0, 1, 0, 0, 16'h0000, 16'h0008, 1, 16'h0000, 32'h0,  2, 0, 16'h0000);
        add(0, 1, 0, 0, 16'h0000, 16'h000C, 1, 16'h0000, 32'h0,  3, 0, 16'h0000);
        add(0, 1, 0, 0, 16'h0000, 16'h0010, 1, 16'h0000, 32'h0,  4, 0, 16'h0000);
        add(0, 1, 0, 0, 16'h0000, 16'h0010, 1, 16'h0000, 32'h0,  4, 0, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h0014, 1, 16'h0004, 32'h1,  4, 0, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h0018, 1, 16'h0008, 32'h2,  4, 0, 16'h0000);
        add(0, 1, 1, 1, 16'h0080, 16'h0080, 0, 16'h0000, 32'h0,  0, 0, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h0084, 1, 16'h0080, 32'h20, 1, 0, 16'h0000);
        add(0, 1, 1, 1, 16'h0042, 16'h0084, 0, 16'h0000, 32'h0,  0, 1, 16'h0042);
        add(0, 1, 1, 1, 16'h0100, 16'h0084, 0, 16'h0000, 32'h0,  0, 1, 16'h0042);
        add(0, 1, 1, 0, 16'h0000, 16'h0084, 0, 16'h0000, 32'h0,  0, 1, 16'h0042);
        add(1, 1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 32'h0,  0, 0, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 32'h0,  0, 0, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h0004, 1, 16'h0000, 32'h0,  1, 0, 16'h0000);

        foreach (vq[k]) begin
            rst = vq[k].rst; en = vq[k].en; inst_ready = vq[k].rdy;
            redirect_valid = vq[k].rv; redirect_pc = vq[k].rpc;
            step();
            chk($sformatf("v%0d im_addr", k),    im_addr,    vq[k].e_addr);
            chk($sformatf("v%0d inst_valid", k), inst_valid, vq[k].e_vld);
            chk($sformatf("v%0d inst_pc", k),    inst_pc,    vq[k].e_pc);
            chk($sformatf("v%0d inst", k),       inst,       vq[k].e_inst);
            chk($sformatf("v%0d q_count", k),    q_count,    vq[k].e_qc);
            chk($sformatf("v%0d fault", k),      fault,      vq[k].e_fault);
            chk($sformatf("v%0d fault_pc", k),   fault_pc,   vq[k].e_fpc);
        end

        // Streaming: one pc/inst pair per cycle, no gaps
        do_reset();
        en = 1'b1; inst_ready = 1'b1;
        step();
        chk("stream first addr", im_addr, 16'h0000);
        for (int k = 0; k < 64; k++) begin
            step();
            chk("stream im_addr", im_addr, 16'((k + 1) * 4));
            chk("stream valid", inst_valid, 1'b1);
            chk("stream inst_pc", inst_pc, 16'(k * 4));
            chk("stream inst", inst, 32'(k));
        end

        // Redirect with three queued entries and a pop in the same cycle
        do_reset();
        en = 1'b1; inst_ready = 1'b0;
        repeat (4) step();
        chk("pre-redirect q_count", q_count, 3'd3);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0080;
        step();
        redirect_valid = 1'b0;
        chk("redirect flush q_count", q_count, 3'd0);
        step();
        chk("redirect target valid", inst_valid, 1'b1);
        chk("redirect target pc", inst_pc, 16'h0080);
        chk("redirect target inst", inst, 32'd32);
        exp_pc = 16'h0084;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("stale pc absent", inst_valid && inst_pc >= 16'h000C && inst_pc <= 16'h0014, 1'b0);
            chk("post-redirect pc", inst_pc, exp_pc);
            exp_pc += 16'h4;
        end

        // Wrap-around at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 16'hFFF8;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap pc0", inst_pc, 16'hFFF8);
        chk("wrap inst0", inst, 32'h3FFE);
        step();
        chk("wrap pc1", inst_pc, 16'hFFFC);
        step();
        chk("wrap pc2", inst_pc, 16'h0000);
        chk("wrap inst2", inst, 32'h0);
        step();
        chk("wrap pc3", inst_pc, 16'h0004);

        // Enable dropped for five cycles: address freezes, queue drains, resumes without a skip
        en = 1'b0;
        step();
        frozen = im_addr;
        chk("frozen addr", frozen, 16'h000C);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("en-off im_addr", im_addr, frozen);
        end
        chk("en-off drained", q_count, 3'd0);
        en = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            step();
            if (inst_valid) seen = 1'b1;
        end
        chk("resume seen within bound", seen, 1'b1);
        chk("resume pc", inst_pc, frozen);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid-run reset q_count", q_count, 3'd0);
        chk("mid-run reset valid", inst_valid, 1'b0);
        chk("mid-run reset im_addr", im_addr, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
